// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract engine: CHUNK bits per clock, LSB chunk first,
// with Z/V/N flags in unsigned or two's-complement interpretation.
module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, stateNext;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opA, opB, acc, resFull;
    logic             signReg, subReg, carry;
    logic [CHUNK-1:0] aChunk, bChunk;
    logic [CHUNK:0]   chunkSum;
    logic             accept, lastChunk, cOut, ov;

    // DONE counts as idle for acceptance so back-to-back operations chain.
    always_comb begin
        accept    = start && (state != RUN);
        lastChunk = (cnt == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) stateNext = RUN;
            RUN: begin
                busy = 1'b1;
                if (lastChunk) stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = start ? RUN : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The full result is the accumulated lower chunks with the current chunk
    // spliced in, so the final edge can register S and flags in one go.
    always_comb begin
        aChunk = '0;
        bChunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                aChunk = opA[i*CHUNK +: CHUNK];
                bChunk = opB[i*CHUNK +: CHUNK];
            end
        end
        chunkSum = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry};
        cOut     = chunkSum[CHUNK];
        resFull  = acc;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) resFull[i*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
        end
        ov = (opA[WIDTH-1] == opB[WIDTH-1]) && (resFull[WIDTH-1] != opA[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            opA     <= '0;
            opB     <= '0;
            acc     <= '0;
            signReg <= 1'b0;
            subReg  <= 1'b0;
            carry   <= 1'b0;
            S       <= '0;
            Z       <= 1'b0;
            V       <= 1'b0;
            N       <= 1'b0;
        end else if (accept) begin
            opA     <= A;
            opB     <= Sub ? ~B : B;
            signReg <= Sign;
            subReg  <= Sub;
            carry   <= Sub;
            cnt     <= '0;
        end else if (state == RUN) begin
            acc   <= resFull;
            carry <= cOut;
            if (lastChunk) begin
                S <= resFull;
                Z <= (resFull == '0);
                if (signReg) begin
                    V <= ov;
                    N <= resFull[WIDTH-1] ^ ov;
                end else if (subReg) begin
                    V <= ~cOut;
                    N <= ~cOut;
                end else begin
                    V <= cOut;
                    N <= 1'b0;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: three instances (CHUNK=8, 1, 32) share
// operands and reset; each has its own start, expected-result queue and monitor.
module tb_addsub_serial;

    localparam int NDUT = 3;

    typedef struct {
        logic [31:0] s;
        logic        z, v, n;
        int          doneCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] aIn = '0, bIn = '0;
    logic        signIn = 1'b0, subIn = 1'b0;
    logic        startV[NDUT];
    logic        busyV[NDUT], doneV[NDUT], zV[NDUT], vV[NDUT], nV[NDUT];
    logic [31:0] sV[NDUT];

    exp_t expQ[NDUT][$];
    exp_t lastRes[NDUT];
    int   cyc = 0;
    logic rstQ = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rstQ <= reset;
    end

    generate
        for (genvar g = 0; g < NDUT; g++) begin : gDut
            localparam int CH = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
            addsub_serial #(.WIDTH(32), .CHUNK(CH)) dut (
                .clk(clk), .reset(reset), .start(startV[g]),
                .A(aIn), .B(bIn), .Sign(signIn), .Sub(subIn),
                .busy(busyV[g]), .done(doneV[g]), .S(sV[g]),
                .Z(zV[g]), .V(vV[g]), .N(nV[g])
            );
        end
    endgenerate

    function automatic int nchunkOf(int d);
        case (d)
            0:       return 4;
            1:       return 32;
            default: return 1;
        endcase
    endfunction

    // Reference: exact arithmetic in wide integers, flags read off the true result.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic sign, logic sub);
        exp_t        e;
        logic [32:0] u;
        longint      sa, sb, ex;
        u = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.s = u[31:0];
        e.z = (e.s == 32'd0);
        e.doneCyc = 0;
        if (sign) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            ex  = sub ? (sa - sb) : (sa + sb);
            e.v = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
            e.n = (ex < 0);
        end else if (sub) begin
            e.v = (a < b);
            e.n = (a < b);
        end else begin
            e.v = u[32];
            e.n = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7, 0))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(string name, int d, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h", name, d, act, req);
        end
    endtask

    // Called just after a negedge; issues one start and scrambles inputs afterwards.
    task automatic applyStimulus(int d, logic [31:0] a, logic [31:0] b, logic sign, logic sub);
        exp_t e;
        aIn = a; bIn = b; signIn = sign; subIn = sub;
        startV[d] = 1'b1;
        e = model(a, b, sign, sub);
        e.doneCyc = cyc + 1 + nchunkOf(d);
        expQ[d].push_back(e);
        @(negedge clk);
        startV[d] = 1'b0;
        aIn = $urandom; bIn = $urandom;
        signIn = 1'($urandom); subIn = 1'($urandom);
    endtask

    task automatic waitDone(int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!doneV[d] && n < nchunkOf(d) + 20);
        if (!doneV[d]) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout dut%0d: no done after %0d cycles, expected a done pulse", d, n);
        end
    endtask

    task automatic checkResult(int d, logic [31:0] s, logic z, logic v, logic n);
        checkOutput("planS", d, 64'(sV[d]), 64'(s));
        checkOutput("planZVN", d, 64'({zV[d], vV[d], nV[d]}), 64'({z, v, n}));
    endtask

    // Monitor: reset clears expectations, done pops and compares, otherwise outputs must hold.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (rstQ) begin
                expQ[d].delete();
                lastRes[d] = '{s: 32'd0, z: 1'b0, v: 1'b0, n: 1'b0, doneCyc: 0};
                checkOutput("resetOutputs", d,
                    64'({busyV[d], doneV[d], zV[d], vV[d], nV[d], sV[d]}), 64'd0);
            end else if (doneV[d]) begin
                if (expQ[d].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpectedDone dut%0d: done at cycle %0d, expected none", d, cyc);
                end else begin
                    e = expQ[d].pop_front();
                    checkOutput("doneCycle", d, 64'(cyc), 64'(e.doneCyc));
                    checkOutput("resultS", d, 64'(sV[d]), 64'(e.s));
                    checkOutput("flagsZVN", d, 64'({zV[d], vV[d], nV[d]}), 64'({e.z, e.v, e.n}));
                    checkOutput("busyInDone", d, 64'(busyV[d]), 64'd0);
                    lastRes[d] = e;
                end
            end else begin
                checkOutput("holdOutputs", d, 64'({zV[d], vV[d], nV[d], sV[d]}),
                    64'({lastRes[d].z, lastRes[d].v, lastRes[d].n, lastRes[d].s}));
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int firstCyc;
        for (int d = 0; d < NDUT; d++) startV[d] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 5 - 7 unsigned: busy for exactly four cycles, then done
        applyStimulus(0, 32'd5, 32'd7, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("busyRun", 0, 64'({busyV[0], doneV[0]}), 64'b10);
            @(negedge clk);
        end
        checkOutput("doneAtLatency", 0, 64'({busyV[0], doneV[0]}), 64'b01);
        checkResult(0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
        @(negedge clk);

        applyStimulus(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        waitDone(0);
        checkResult(0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        waitDone(0);
        checkResult(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        waitDone(0);
        checkResult(0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        waitDone(0);
        checkResult(0, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1);
        waitDone(0);
        checkResult(0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // start pulsed mid-run with other operands must be ignored
        applyStimulus(0, 32'd100, 32'd23, 1'b0, 1'b0);
        @(negedge clk);
        aIn = 32'hDEAD_BEEF; bIn = 32'h1111_1111; subIn = 1'b1; startV[0] = 1'b1;
        @(negedge clk);
        startV[0] = 1'b0;
        waitDone(0);
        checkResult(0, 32'd123, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        // start in the DONE cycle chains a second operation
        applyStimulus(0, 32'd40, 32'd2, 1'b1, 1'b1);
        waitDone(0);
        firstCyc = cyc;
        applyStimulus(0, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0);
        waitDone(0);
        checkOutput("backToBackGap", 0, 64'(cyc - firstCyc), 64'd5);
        checkResult(0, 32'h0000_0010, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // reset two cycles after accept aborts with no done
        applyStimulus(0, 32'd9, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortOutputs", 0,
            64'({busyV[0], doneV[0], zV[0], vV[0], nV[0], sV[0]}), 64'd0);
        repeat (8) @(negedge clk);
        applyStimulus(0, 32'd9, 32'd4, 1'b0, 1'b1);
        waitDone(0);
        checkResult(0, 32'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // reset and start together: reset wins
        reset = 1'b1; startV[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0; startV[0] = 1'b0;
        checkOutput("resetWinsBusy", 0, 64'(busyV[0]), 64'd0);
        repeat (8) @(negedge clk);

        // randomized sweeps, mostly back-to-back with occasional idle gaps
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < ((d == 0) ? 200 : 1000); i++) begin
                if ($urandom_range(3, 0) == 0) @(negedge clk);
                applyStimulus(d, pick(), pick(), 1'($urandom), 1'($urandom));
                waitDone(d);
            end
            repeat (3) @(negedge clk);
        end

        for (int d = 0; d < NDUT; d++) begin
            if (expQ[d].size() != 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL pendingResults dut%0d: %0d left, expected 0", d, expQ[d].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
